// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // One pending register write: destination plus data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_W-1:0]      data;
    } wb_req_t;

    // Writes to r0 are architecturally discarded.
    function automatic logic is_live(input logic [REG_ADDR_W-1:0] addr);
        return addr != ZERO_REG;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular FIFO holding mult/div results waiting for the regfile port.
// Push is ignored when full and pop is ignored when empty. The per-entry
// valid/addr vectors let the top answer hazard queries without popping.
module wb_result_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                                clock,
    input  logic                                ctrl_reset,
    input  logic                                push,
    input  wb_req_t                             push_req,
    input  logic                                pop,
    output wb_req_t                             head,
    output logic                                full,
    output logic                                empty,
    output logic [CW-1:0]                       count,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_reg
);

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_req;
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off            = PW'(i) - rd_ptr;
            entry_valid[i] = (CW'(off) < count);
            entry_reg[i]   = mem[i].addr;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Writeback arbiter in front of the 32x32 register file write port.
// The in-order pipeline always wins; mult/div results wait in a FIFO and
// drain in cycles the pipeline leaves free. A starvation counter raises
// stall_req so a waiting head is guaranteed a slot.
// Optional build macro: REGFILE_WB_BYPASS_EN lets a mult/div result skip the
// FIFO when the FIFO is empty and the pipeline is not writing.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [REG_W-1:0]      wb_data,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_reg,
    input  logic [REG_W-1:0]      md_data,
    output logic                  stall_req,
    input  logic [REG_ADDR_W-1:0] chk_reg,
    output logic                  chk_pending,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [REG_W-1:0]      data_writeReg
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Handshake: an md result transfers on a clock edge where md_valid and
    // md_ready are both 1. md_ready comes only from registered FIFO state,
    // so it never depends on md_valid in the same cycle.

    logic                                eff_wb;
    logic                                md_fire;
    logic                                fifo_push;
    logic                                fifo_pop;
    wb_req_t                             fifo_head;
    wb_req_t                             md_req;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic [CW-1:0]                       fifo_count;
    logic [DEPTH-1:0]                    entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_reg;
    logic [SW-1:0]                       starve_cnt;
    logic [SW-1:0]                       starve_nxt;

    assign eff_wb   = wb_valid && is_live(wb_reg);
    assign md_ready = !fifo_full;
    assign md_fire  = md_valid && md_ready;
    assign md_req   = '{addr: md_reg, data: md_data};
    assign fifo_pop = !eff_wb && !fifo_empty;

`ifdef REGFILE_WB_BYPASS_EN
    logic bypass;
    assign bypass    = fifo_empty && !eff_wb && md_fire && is_live(md_reg);
    assign fifo_push = md_fire && is_live(md_reg) && !bypass;
`else
    assign fifo_push = md_fire && is_live(md_reg);
`endif

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .push        (fifo_push),
        .push_req    (md_req),
        .pop         (fifo_pop),
        .head        (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .entry_valid (entry_valid),
        .entry_reg   (entry_reg)
    );

    // Registered output stage: pipeline first, then FIFO head, else idle (addr/data hold).
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else if (eff_wb) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= wb_reg;
            data_writeReg    <= wb_data;
        end else if (fifo_pop) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= fifo_head.addr;
            data_writeReg    <= fifo_head.data;
`ifdef REGFILE_WB_BYPASS_EN
        end else if (bypass) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= md_reg;
            data_writeReg    <= md_data;
`endif
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

    // A non-empty FIFO that is not popped has lost to the pipeline this cycle.
    always_comb begin
        starve_nxt = starve_cnt;
        if (fifo_count == '0 || fifo_pop) begin
            starve_nxt = '0;
        end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    // Starvation counter and its registered stall flag move together.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            stall_req  <= (starve_nxt == SW'(STARVE_MAX));
        end
    end

    // Hazard query covers queued results and the write currently on the port.
    always_comb begin
        chk_pending = ctrl_writeEnable && (ctrl_writeReg == chk_reg);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && entry_reg[i] == chk_reg) chk_pending = 1'b1;
        end
        if (!is_live(chk_reg)) chk_pending = 1'b0;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (default build, DEPTH=2, STARVE_MAX=4).
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        md_valid = 1'b0;
    logic        md_ready;
    logic [4:0]  md_reg = '0;
    logic [31:0] md_data = '0;
    logic        stall_req;
    logic [4:0]  chk_reg = '0;
    logic        chk_pending;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .wb_valid         (wb_valid),
        .wb_reg           (wb_reg),
        .wb_data          (wb_data),
        .md_valid         (md_valid),
        .md_ready         (md_ready),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .stall_req        (stall_req),
        .chk_reg          (chk_reg),
        .chk_pending      (chk_pending),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
        check_value({tag, "_we"}, {31'b0, ctrl_writeEnable}, {31'b0, we});
        check_value({tag, "_reg"}, {27'b0, ctrl_writeReg}, {27'b0, rd});
        check_value({tag, "_data"}, data_writeReg, data);
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v;
        wb_reg   = rd;
        wb_data  = d;
    endtask

    task automatic drive_md(input logic v, input logic [4:0] rd, input logic [31:0] d);
        md_valid = v;
        md_reg   = rd;
        md_data  = d;
    endtask

    task automatic check_pending(input string tag, input logic [4:0] rd, input logic exp);
        chk_reg = rd;
        #1;
        check_value(tag, {31'b0, chk_pending}, {31'b0, exp});
    endtask

    // The pipeline must not write while a stall is requested.
    always @(posedge clock) begin
        if (ctrl_reset && stall_req) check_value("stall_protocol", {31'b0, wb_valid}, 32'd0);
    end

    initial begin
        // 1: reset then idle
        tick();
        tick();
        check_port("rst", 1'b0, 5'd0, 32'd0);
        check_value("rst_stall", {31'b0, stall_req}, 32'd0);
        check_value("rst_md_ready", {31'b0, md_ready}, 32'd1);
        check_value("rst_pending", {31'b0, chk_pending}, 32'd0);
        ctrl_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_value("idle_we", {31'b0, ctrl_writeEnable}, 32'd0);
            check_value("idle_stall", {31'b0, stall_req}, 32'd0);
        end

        // 2: pipeline wins, mult/div lands one cycle later
        drive_wb(1'b1, 5'd3, 32'hAAAA0001);
        drive_md(1'b1, 5'd5, 32'h12345678);
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        drive_md(1'b0, 5'd0, 32'd0);
        check_port("prio_wb", 1'b1, 5'd3, 32'hAAAA0001);
        check_value("prio_md_ready", {31'b0, md_ready}, 32'd1);
        check_pending("prio_pend_r5", 5'd5, 1'b1);
        tick();
        check_port("prio_md", 1'b1, 5'd5, 32'h12345678);
        tick();
        check_port("prio_idle_hold", 1'b0, 5'd5, 32'h12345678);
        check_pending("prio_empty_r5", 5'd5, 1'b0);

        // 3: r0 pipeline write is dropped and the FIFO head takes the slot
        drive_wb(1'b1, 5'd2, 32'h00000022);
        drive_md(1'b1, 5'd7, 32'h00000007);
        tick();
        drive_wb(1'b1, 5'd0, 32'hFFFFFFFF);
        drive_md(1'b0, 5'd0, 32'd0);
        check_port("zero_pre", 1'b1, 5'd2, 32'h00000022);
        check_pending("zero_pend_r7", 5'd7, 1'b1);
        check_pending("zero_pend_r0", 5'd0, 1'b0);
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        check_port("zero_r7", 1'b1, 5'd7, 32'h00000007);
        tick();
        check_value("zero_after_we", {31'b0, ctrl_writeEnable}, 32'd0);
        // md result for r0 completes the handshake but is never written
        drive_md(1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        drive_md(1'b0, 5'd0, 32'd0);
        tick();
        check_value("md_r0_we", {31'b0, ctrl_writeEnable}, 32'd0);
        check_value("md_r0_ready", {31'b0, md_ready}, 32'd1);

        // 4: backpressure and starvation
        drive_wb(1'b1, 5'd1, 32'h00000011);
        drive_md(1'b1, 5'd11, 32'h000000B1);
        tick();
        check_value("bp_ready_1", {31'b0, md_ready}, 32'd1);
        drive_md(1'b1, 5'd12, 32'h000000B2);
        tick();
        drive_md(1'b1, 5'd13, 32'h000000B3);
        check_value("bp_ready_full", {31'b0, md_ready}, 32'd0);
        check_value("bp_stall_1", {31'b0, stall_req}, 32'd0);
        check_port("bp_wb", 1'b1, 5'd1, 32'h00000011);
        tick();
        check_value("bp_stall_2", {31'b0, stall_req}, 32'd0);
        tick();
        check_value("bp_stall_3", {31'b0, stall_req}, 32'd0);
        check_value("bp_ready_held", {31'b0, md_ready}, 32'd0);
        tick();
        check_value("bp_stall_4", {31'b0, stall_req}, 32'd1);
        drive_wb(1'b0, 5'd0, 32'd0);
        tick();
        check_port("bp_drain_11", 1'b1, 5'd11, 32'h000000B1);
        check_value("bp_stall_clr", {31'b0, stall_req}, 32'd0);
        check_value("bp_ready_back", {31'b0, md_ready}, 32'd1);
        tick();
        drive_md(1'b0, 5'd0, 32'd0);
        check_port("bp_drain_12", 1'b1, 5'd12, 32'h000000B2);
        tick();
        check_port("bp_drain_13", 1'b1, 5'd13, 32'h000000B3);
        tick();
        check_value("bp_done_we", {31'b0, ctrl_writeEnable}, 32'd0);

        // 5: hazard query
        drive_wb(1'b1, 5'd4, 32'h00000044);
        drive_md(1'b1, 5'd9, 32'h00000099);
        tick();
        drive_md(1'b0, 5'd0, 32'd0);
        check_pending("haz_fifo_r9", 5'd9, 1'b1);
        check_pending("haz_r10", 5'd10, 1'b0);
        check_pending("haz_port_r4", 5'd4, 1'b1);
        drive_wb(1'b0, 5'd0, 32'd0);
        tick();
        check_port("haz_r9_port", 1'b1, 5'd9, 32'h00000099);
        check_pending("haz_port_r9", 5'd9, 1'b1);
        tick();
        check_pending("haz_after_r9", 5'd9, 1'b0);

        // 6: reset mid-operation discards queued results
        drive_wb(1'b1, 5'd1, 32'h00000011);
        drive_md(1'b1, 5'd20, 32'h00000020);
        tick();
        drive_md(1'b1, 5'd21, 32'h00000021);
        tick();
        drive_md(1'b0, 5'd0, 32'd0);
        check_value("mid_full", {31'b0, md_ready}, 32'd0);
        drive_wb(1'b0, 5'd0, 32'd0);
        ctrl_reset = 1'b0;
        tick();
        ctrl_reset = 1'b1;
        check_port("mid_rst", 1'b0, 5'd0, 32'd0);
        check_value("mid_stall", {31'b0, stall_req}, 32'd0);
        check_value("mid_ready", {31'b0, md_ready}, 32'd1);
        check_pending("mid_pend_r20", 5'd20, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("mid_no_write", {31'b0, ctrl_writeEnable}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Writeback stage directly upstream of the 32x32 register file write port.
- Merges two write sources onto the single regfile write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg):
  - the in-order pipeline writeback, which is never stalled;
  - the multicycle mult/div unit, whose results are buffered in a small FIFO.
- Adds a starvation-driven stall request and a pending-write hazard query for decode.

Parameters:
- DEPTH, 2, mult/div result FIFO entries (power of two, >= 2).
- STARVE_MAX, 4, cycles a valid FIFO head may lose arbitration before stall_req asserts.

Ports:
- clock  in  1  system clock, rising edge.
- ctrl_reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- wb_valid  in  1  pipeline writeback request; always accepted.
- wb_reg  in  5  pipeline destination register.
- wb_data  in  32  pipeline writeback data.
- md_valid  in  1  mult/div result valid.
- md_ready  out  1  FIFO can accept; transfer occurs when md_valid & md_ready.
- md_reg  in  5  mult/div destination register.
- md_data  in  32  mult/div result.
- stall_req  out  1  pipeline must present wb_valid=0 in the next cycle.
- chk_reg  in  5  register queried by decode.
- chk_pending  out  1  chk_reg has an outstanding write (FIFO or output stage).
- ctrl_writeEnable  out  1  to regfile.
- ctrl_writeReg  out  5  to regfile.
- data_writeReg  out  32  to regfile.

Behaviour:
- Reset (ctrl_reset=0 at the clock edge) clears the following; reset mid-operation discards all queued results:
  - ctrl_writeEnable, ctrl_writeReg, data_writeReg, stall_req all 0;
  - FIFO empty, md_ready=1, starve counter 0.
- Output stage is registered: a write selected in cycle N appears on the regfile port in cycle N+1 for exactly one cycle.
- "Effective pipeline write" = wb_valid & (wb_reg != 0).
- Arbitration each cycle:
  - If there is an effective pipeline write, the output stage loads the pipeline write.
  - Otherwise, if the FIFO is non-empty, the output stage loads the FIFO head and the FIFO pops.
  - Otherwise ctrl_writeEnable=0 next cycle; ctrl_writeReg and data_writeReg hold their previous values.
- Register 0:
  - Any write targeting register 0, from either source, is dropped and never raises ctrl_writeEnable.
  - A mult/div result with md_reg=0 is accepted (handshake completes) but not enqueued.
- FIFO:
  - Circular pointers with wrap at DEPTH and occupancy count 0..DEPTH.
  - md_ready = (count != DEPTH). It depends only on registered state; there is no same-cycle full pass-through.
  - Push and pop in the same cycle leave count unchanged; ordering is FIFO.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and loses to the pipeline.
  - It clears on any pop or when the FIFO is empty, and saturates at STARVE_MAX.
  - stall_req = (counter == STARVE_MAX), registered.
  - The pipeline guarantees wb_valid=0 in the cycle after stall_req=1, so the head drains and the counter clears.
  - If wb_valid=1 while stall_req=1, the pipeline still wins (protocol violation; flagged by assertion in the bench).
- chk_pending:
  - Combinational.
  - 1 if chk_reg != 0 and chk_reg matches any valid FIFO entry, or matches ctrl_writeReg while ctrl_writeEnable=1.
  - Same-cycle incoming md/wb writes are not included.
- Simultaneous pipeline write and mult/div write to the same register: the pipeline write lands first and the FIFO result lands later, so the mult/div value is final.

Optional Feature:
- REGFILE_WB_BYPASS_EN.
- When defined: if the FIFO is empty, there is no effective pipeline write, and md_valid=1 with md_reg != 0, the result goes straight into the output stage (one-cycle latency) without being enqueued.
- When undefined: every mult/div result is enqueued first, so minimum mult/div-to-regfile latency is 2 cycles.
- Handshake and md_ready rules are identical in both builds.

Decomposition:
- Shared package regfile_pkg:
  - REG_W=32, REG_ADDR_W=5, ZERO_REG=5'd0;
  - struct/typedef wb_req_t {reg[4:0], data[31:0]}.
- One natural sub-module: wb_result_fifo.
  - Parameterised DEPTH FIFO of wb_req_t.
  - Exposes push/pop/full/empty/count and a per-entry valid+reg vector for the chk_pending compare.

Test Plan:
1. Reset then idle: hold ctrl_reset=0 for 2 cycles, release -> all outputs 0, md_ready=1, no ctrl_writeEnable for 10 idle cycles.
2. Pipeline priority: wb_valid=1, wb_reg=3, wb_data=0xAAAA0001 concurrently with md_valid=1, md_reg=5, md_data=0x12345678 -> port writes r3 in cycle N+1 and r5 in cycle N+2 (if wb idle); FIFO empty afterward.
3. Zero register: wb_reg=0, wb_data=0xFFFFFFFF with FIFO holding r7=0x7 -> no write to r0; r7 written in the next cycle (FIFO drains in the r0 slot).
4. Full/backpressure: wb_valid=1 (r1) continuously, push 3 md results -> md_ready=0 after 2 accepted (DEPTH=2); stall_req rises after STARVE_MAX=4 losses; after wb_valid=0, entries drain in order; md_ready returns to 1 and the third push completes.
5. Hazard query: FIFO holds r9, chk_reg=9 -> chk_pending=1; chk_reg=10 -> 0; once r9 is on the port -> still 1; cycle after -> 0.
6. Reset mid-operation: FIFO full, assert ctrl_reset=0 for one edge -> FIFO empties, ctrl_writeEnable=0, stall_req=0, queued results never reach the regfile.
